// File: rtl/msoc_uart_ctrl_if.sv
// -----------------------------------------------------------------------------
// msoc_uart_ctrl_if
// Register bus between a host and the UART controller.
//   req   : single-cycle access strobe (host -> UART)
//   we    : 1 = write, 0 = read         (host -> UART)
//   addr  : word offset                 (host -> UART)
//   wdata : write data                  (host -> UART)
//   rdata : registered read data, valid the cycle after a read (UART -> host)
// -----------------------------------------------------------------------------
interface msoc_uart_ctrl_if;
  logic        req;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output req, output we, output addr, output wdata, input rdata);
  modport slave  (input req, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/msoc_uart_ctrl.sv
// -----------------------------------------------------------------------------
// msoc_uart_ctrl
// UART with TX/RX FIFOs, programmable divisor, sticky error flags and a
// level interrupt, reached through a small word-addressed register bus.
// Ports:
//   i_msoc_clk : sole clock, rising edge
//   i_rst      : synchronous active-high reset
//   bus        : register bus (slave side) - req/we/addr/wdata/rdata
//   i_uart_rx  : asynchronous serial input
//   o_uart_tx  : serial output, idle high (registered)
//   o_irq      : level interrupt (registered)
// Register map: 0 TXDATA, 1 BAUD, 2 RXDATA, 3 STATUS, 4 IRQ_EN, 5..7 reserved.
// -----------------------------------------------------------------------------
module msoc_uart_ctrl #(
  parameter int          DATA_BITS    = 8,
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [15:0] DEFAULT_BAUD = 16'd87
) (
  input  logic              i_msoc_clk,
  input  logic              i_rst,
  msoc_uart_ctrl_if.slave   bus,
  input  logic              i_uart_rx,
  output logic              o_uart_tx,
  output logic              o_irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int RX_W  = DATA_BITS + 1;
  localparam logic [TX_CW-1:0] TX_CNT_MAX = TX_DEPTH[TX_CW-1:0];
  localparam logic [RX_CW-1:0] RX_CNT_MAX = RX_DEPTH[RX_CW-1:0];
  localparam logic [3:0]       LAST_BIT   = 4'(DATA_BITS - 1);

  localparam logic [2:0] A_TXDATA = 3'd0;
  localparam logic [2:0] A_BAUD   = 3'd1;
  localparam logic [2:0] A_RXDATA = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_IRQ_EN = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- registers ----------------
  logic [15:0]          r_baud;
  logic [2:0]           r_irq_en;
  logic                 r_tx_ovf, r_rx_ovf, r_frame_err, r_rx_udf;
  logic [31:0]          r_rdata;
  logic                 r_irq;
  logic                 r_uart_tx;

  logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]     r_tx_wptr, r_tx_rptr;
  logic [TX_CW-1:0]     r_tx_cnt;
  logic [RX_W-1:0]      r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]     r_rx_wptr, r_rx_rptr;
  logic [RX_CW-1:0]     r_rx_cnt;

  state_t               r_tx_state, w_tx_state_nxt;
  logic [15:0]          r_tx_tmr, w_tx_tmr_nxt, r_tx_div, w_tx_div_nxt;
  logic [DATA_BITS-1:0] r_tx_sh, w_tx_sh_nxt;
  logic [3:0]           r_tx_bit, w_tx_bit_nxt;
  logic                 w_tx_line_nxt, w_tx_pop;

  logic                 r_rx_meta, r_rx_sync;
  state_t               r_rx_state, w_rx_state_nxt;
  logic [15:0]          r_rx_tmr, w_rx_tmr_nxt, r_rx_div, w_rx_div_nxt;
  logic [DATA_BITS-1:0] r_rx_sh, w_rx_sh_nxt;
  logic [3:0]           r_rx_bit, w_rx_bit_nxt;
  logic                 w_rx_push_req;

  // ---------------- decode / status wires ----------------
  logic        w_wr, w_rd, w_tx_wr_req, w_tx_push, w_rx_rd_req, w_rx_pop, w_rx_push;
  logic        w_stat_wr;
  logic        w_tx_full, w_tx_empty, w_tx_busy, w_rx_full, w_rx_empty, w_rx_busy;
  logic [15:0] w_baud_eff;
  logic [16:0] w_rx_sum;
  logic [15:0] w_rx_half_m1;
  logic [31:0] w_status, w_rdata_nxt;
  logic        w_irq_nxt;
  logic        w_unused_wdata;

  assign w_wr        = bus.req & bus.we;
  assign w_rd        = bus.req & ~bus.we;
  assign w_stat_wr   = w_wr & (bus.addr == A_STATUS);
  assign w_tx_wr_req = w_wr & (bus.addr == A_TXDATA);
  assign w_rx_rd_req = w_rd & (bus.addr == A_RXDATA);

  assign w_tx_full  = (r_tx_cnt == TX_CNT_MAX);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == RX_CNT_MAX);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_tx_busy  = (r_tx_state != S_IDLE);
  assign w_rx_busy  = (r_rx_state != S_IDLE);

  // Fullness is judged on the count before any same-cycle pop.
  assign w_tx_push = w_tx_wr_req & ~w_tx_full;
  assign w_rx_push = w_rx_push_req & ~w_rx_full;
  assign w_rx_pop  = w_rx_rd_req & ~w_rx_empty;

  // Divisors 0 and 1 both give a two-cycle bit period.
  assign w_baud_eff   = (r_baud < 16'd2) ? 16'd1 : r_baud;
  // Start-bit half period (BAUD+1)/2, expressed as a terminal count.
  assign w_rx_sum     = {1'b0, r_rx_div} + 17'd1;
  assign w_rx_half_m1 = w_rx_sum[16:1] - 16'd1;

  assign w_unused_wdata = ^bus.wdata;

  assign w_status = {8'(r_tx_cnt), 8'(r_rx_cnt), 6'd0,
                     r_rx_udf, r_frame_err, r_tx_ovf, r_rx_ovf,
                     w_rx_busy, w_tx_busy, w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

  assign bus.rdata = r_rdata;
  assign o_uart_tx = r_uart_tx;
  assign o_irq     = r_irq;

  // Writable configuration registers.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_baud   <= DEFAULT_BAUD;
      r_irq_en <= 3'd0;
    end else begin
      if (w_wr && (bus.addr == A_BAUD))   r_baud   <= bus.wdata[15:0];
      if (w_wr && (bus.addr == A_IRQ_EN)) r_irq_en <= bus.wdata[2:0];
    end
  end

  // Sticky flags: a set event in the same cycle beats a STATUS clear.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_rx_ovf    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_udf    <= 1'b0;
    end else begin
      r_rx_ovf    <= (w_rx_push_req & w_rx_full) | (r_rx_ovf & ~(w_stat_wr & bus.wdata[6]));
      r_tx_ovf    <= (w_tx_wr_req & w_tx_full) | (r_tx_ovf & ~(w_stat_wr & bus.wdata[7]));
      r_frame_err <= (w_rx_push_req & ~r_rx_sync) | (r_frame_err & ~(w_stat_wr & bus.wdata[8]));
      r_rx_udf    <= (w_rx_rd_req & w_rx_empty) | (r_rx_udf & ~(w_stat_wr & bus.wdata[9]));
    end
  end

  // TX FIFO storage (no reset needed on the data array).
  always_ff @(posedge i_msoc_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.wdata[DATA_BITS-1:0];
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + TX_AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + TX_AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + TX_CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - TX_CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  // RX FIFO storage; entries are {err, data}.
  always_ff @(posedge i_msoc_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= {~r_rx_sync, r_rx_sh};
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + RX_AW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + RX_AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + RX_CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - RX_CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  // TX FSM state register and datapath.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_tx_state <= S_IDLE;
      r_tx_tmr   <= 16'd0;
      r_tx_div   <= 16'd1;
      r_tx_sh    <= '0;
      r_tx_bit   <= 4'd0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_tmr   <= w_tx_tmr_nxt;
      r_tx_div   <= w_tx_div_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_uart_tx  <= w_tx_line_nxt;
    end
  end

  // TX FSM next state: the line value is produced alongside the state so the
  // pin changes on the same edge as the state.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_tmr_nxt   = r_tx_tmr;
    w_tx_div_nxt   = r_tx_div;
    w_tx_sh_nxt    = r_tx_sh;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_line_nxt  = r_uart_tx;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = S_START;
          w_tx_div_nxt   = w_baud_eff;
          w_tx_tmr_nxt   = 16'd0;
          w_tx_sh_nxt    = r_tx_mem[r_tx_rptr];
          w_tx_line_nxt  = 1'b0;
        end else begin
          w_tx_line_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (r_tx_tmr == r_tx_div) begin
          w_tx_state_nxt = S_DATA;
          w_tx_tmr_nxt   = 16'd0;
          w_tx_bit_nxt   = 4'd0;
          w_tx_line_nxt  = r_tx_sh[0];
        end else begin
          w_tx_tmr_nxt   = r_tx_tmr + 16'd1;
        end
      end
      S_DATA: begin
        if (r_tx_tmr == r_tx_div) begin
          w_tx_tmr_nxt = 16'd0;
          if (r_tx_bit == LAST_BIT) begin
            w_tx_state_nxt = S_STOP;
            w_tx_line_nxt  = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 4'd1;
            w_tx_sh_nxt    = {1'b0, r_tx_sh[DATA_BITS-1:1]};
            w_tx_line_nxt  = r_tx_sh[1];
          end
        end else begin
          w_tx_tmr_nxt = r_tx_tmr + 16'd1;
        end
      end
      S_STOP: begin
        if (r_tx_tmr == r_tx_div) begin
          w_tx_state_nxt = S_IDLE;
          w_tx_tmr_nxt   = 16'd0;
        end else begin
          w_tx_tmr_nxt   = r_tx_tmr + 16'd1;
        end
      end
      default: begin
        w_tx_state_nxt = S_IDLE;
        w_tx_line_nxt  = 1'b1;
      end
    endcase
  end

  // Two-flop synchronizer for the asynchronous serial input (idles high).
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX FSM state register and datapath.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_rx_state <= S_IDLE;
      r_rx_tmr   <= 16'd0;
      r_rx_div   <= 16'd1;
      r_rx_sh    <= '0;
      r_rx_bit   <= 4'd0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_tmr   <= w_rx_tmr_nxt;
      r_rx_div   <= w_rx_div_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
    end
  end

  // RX FSM next state: mid-bit sampling, bits shifted in from the MSB end so
  // the first (LSB) sample ends at bit 0.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_tmr_nxt   = r_rx_tmr;
    w_rx_div_nxt   = r_rx_div;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_push_req  = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nxt = S_START;
          w_rx_tmr_nxt   = 16'd0;
          w_rx_div_nxt   = w_baud_eff;
        end else begin
          w_rx_tmr_nxt   = 16'd0;
        end
      end
      S_START: begin
        if (r_rx_tmr == w_rx_half_m1) begin
          w_rx_tmr_nxt = 16'd0;
          w_rx_bit_nxt = 4'd0;
          if (r_rx_sync) begin
            w_rx_state_nxt = S_IDLE;  // glitch: line back high mid start bit
          end else begin
            w_rx_state_nxt = S_DATA;
          end
        end else begin
          w_rx_tmr_nxt = r_rx_tmr + 16'd1;
        end
      end
      S_DATA: begin
        if (r_rx_tmr == r_rx_div) begin
          w_rx_tmr_nxt = 16'd0;
          w_rx_sh_nxt  = {r_rx_sync, r_rx_sh[DATA_BITS-1:1]};
          if (r_rx_bit == LAST_BIT) begin
            w_rx_state_nxt = S_STOP;
          end else begin
            w_rx_bit_nxt   = r_rx_bit + 4'd1;
          end
        end else begin
          w_rx_tmr_nxt = r_rx_tmr + 16'd1;
        end
      end
      S_STOP: begin
        if (r_rx_tmr == r_rx_div) begin
          w_rx_push_req  = 1'b1;
          w_rx_state_nxt = S_IDLE;
          w_rx_tmr_nxt   = 16'd0;
        end else begin
          w_rx_tmr_nxt   = r_rx_tmr + 16'd1;
        end
      end
      default: begin
        w_rx_state_nxt = S_IDLE;
      end
    endcase
  end

  // Read-data mux; TXDATA and reserved offsets read as zero.
  always_comb begin
    w_rdata_nxt = 32'd0;
    case (bus.addr)
      A_BAUD:   w_rdata_nxt = {16'd0, r_baud};
      A_RXDATA: begin
        if (w_rx_empty) begin
          w_rdata_nxt = 32'd0;
        end else begin
          w_rdata_nxt = 32'(r_rx_mem[r_rx_rptr]);
        end
      end
      A_STATUS: w_rdata_nxt = w_status;
      A_IRQ_EN: w_rdata_nxt = {29'd0, r_irq_en};
      default:  w_rdata_nxt = 32'd0;
    endcase
  end

  // Registered read data, updated only on reads.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_rdata <= 32'd0;
    end else if (w_rd) begin
      r_rdata <= w_rdata_nxt;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign w_irq_nxt = (r_irq_en[0] & ~w_rx_empty) |
                     (r_irq_en[1] & w_tx_empty & ~w_tx_busy) |
                     (r_irq_en[2] & (r_rx_ovf | r_tx_ovf | r_frame_err | r_rx_udf));

  // Registered interrupt level.
  always_ff @(posedge i_msoc_clk) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_nxt;
    end
  end

endmodule
